cpu_mem_arbiter: RTL and testbench

Shares one SRAM-like memory port between the IF-stage instruction requester and the EXE/MEM-stage data requester. Requests use a req/addr_ok/data_ok split handshake. The arbiter grants one request per cycle and tracks outstanding transactions in an in-order source FIFO, so each returned data_ok/rdata is routed back to the requester that issued it. It sits between mycpu_top's stages and the single external memory bridge.

---
 rtl/cpu_mem_arbiter_if.sv | 41 ++++
 rtl/cpu_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_cpu_mem_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter_if
// SRAM-like split-handshake bus (req/addr_ok/data_ok). One instance is used
// for each requester (inst, data) and one for the shared memory port.
//
// Signals:
//   req      request valid, held by the master until addr_ok
//   wr       1 = write, 0 = read
//   size     0 = byte, 1 = half, 2 = word
//   addr     byte address
//   wstrb    byte write strobes
//   wdata    write data
//   addr_ok  request accepted this cycle
//   data_ok  response (read data or write ack) this cycle
//   rdata    read data, valid with data_ok
//
// Modports:
//   master   issues requests, receives responses
//   slave    accepts requests, returns responses
// ---------------------------------------------------------------------------
interface cpu_mem_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cpu_mem_arbiter
// Shares one SRAM-like memory port between the instruction-fetch requester
// and the data requester. One request is granted per cycle (data has
// priority, with a starvation guard for inst). The source of every accepted
// request is pushed into an in-order FIFO so each in-order memory response
// is routed back to the requester that issued it.
//
// Parameters:
//   OUTSTANDING  max in-flight transactions (source FIFO depth), power of 2
//   CNT_W        width of outstanding_cnt, log2(OUTSTANDING)+1
//
// Ports:
//   clk              rising-edge clock
//   resetn           asynchronous active-low reset
//   inst             instruction requester (slave side); only req/addr used
//   data             data requester (slave side)
//   mem              shared memory port (master side)
//   outstanding_cnt  issued but unanswered transactions
//   err_stray        sticky: a response arrived with nothing outstanding
// ---------------------------------------------------------------------------
module cpu_mem_arbiter #(
    parameter int OUTSTANDING = 4,
    parameter int CNT_W       = 3
) (
    input  logic                     clk,
    input  logic                     resetn,
    cpu_mem_arbiter_if.slave         inst,
    cpu_mem_arbiter_if.slave         data,
    cpu_mem_arbiter_if.master        mem,
    output logic [CNT_W-1:0]         outstanding_cnt,
    output logic                     err_stray
);

    localparam int PTR_W = CNT_W - 1;

    typedef enum logic {
        SRC_INST = 1'b0,
        SRC_DATA = 1'b1
    } src_e;

    src_e             src_fifo [OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [2:0]       starve_cnt;

    logic full;
    logic empty;
    logic inst_starved;
    logic grant_data;
    logic grant_inst;
    logic push;
    logic pop;
    src_e head;

    assign full         = (outstanding_cnt == CNT_W'(OUTSTANDING));
    assign empty        = (outstanding_cnt == '0);
    assign inst_starved = (starve_cnt == 3'd4);

    // A pop in the same cycle does not free a slot for a grant: full is
    // taken from the registered count only, keeping the grant path short.
    assign grant_data = !full && data.req && !(inst_starved && inst.req);
    assign grant_inst = !full && inst.req && !grant_data;

    assign push = mem.addr_ok && mem.req;
    assign pop  = mem.data_ok && !empty;
    assign head = src_fifo[rd_ptr];

    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        mem.req   = 1'b0;
        mem.wr    = 1'b0;
        mem.size  = 2'd0;
        mem.addr  = '0;
        mem.wstrb = '0;
        mem.wdata = '0;
        if (grant_data) begin
            mem.req   = 1'b1;
            mem.wr    = data.wr;
            mem.size  = data.size;
            mem.addr  = data.addr;
            mem.wstrb = data.wstrb;
            mem.wdata = data.wdata;
        end else if (grant_inst) begin
            mem.req   = 1'b1;
            mem.size  = 2'd2;
            mem.addr  = inst.addr;
        end
    end

    assign inst.addr_ok = grant_inst && mem.addr_ok;
    assign data.addr_ok = grant_data && mem.addr_ok;

    assign inst.data_ok = pop && (head == SRC_INST);
    assign data.data_ok = pop && (head == SRC_DATA);
    assign inst.rdata   = inst.data_ok ? mem.rdata : '0;
    assign data.rdata   = data.data_ok ? mem.rdata : '0;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            outstanding_cnt <= '0;
            err_stray       <= 1'b0;
            starve_cnt      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   outstanding_cnt <= outstanding_cnt + 1'b1;
                2'b01:   outstanding_cnt <= outstanding_cnt - 1'b1;
                default: outstanding_cnt <= outstanding_cnt;
            endcase

            if (mem.data_ok && empty) err_stray <= 1'b1;

            // Counts data grants accepted while inst is waiting.
            if (!inst.req || (push && grant_inst)) begin
                starve_cnt <= '0;
            end else if (push && grant_data && !inst_starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    // NOTE: the FIFO storage is deliberately not reset; entries are only
    // read while outstanding_cnt says they are valid, and the pointers are.
    always_ff @(posedge clk) begin
        if (push) src_fifo[wr_ptr] <= grant_data ? SRC_DATA : SRC_INST;
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cpu_mem_arbiter
// Directed-vector bench for cpu_mem_arbiter. Inputs are driven 1 ns after
// the rising edge; combinational outputs are checked 1 ns after the inputs
// settle, registered outputs 1 ns after the edge.
// ---------------------------------------------------------------------------
module tb_cpu_mem_arbiter;

    logic       clk;
    logic       resetn;
    logic [2:0] outstanding_cnt;
    logic       err_stray;

    int vectors     = 0;
    int miscompares = 0;

    cpu_mem_arbiter_if inst_if ();
    cpu_mem_arbiter_if data_if ();
    cpu_mem_arbiter_if mem_if ();

    cpu_mem_arbiter #(
        .OUTSTANDING (4),
        .CNT_W       (3)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst            (inst_if),
        .data            (data_if),
        .mem             (mem_if),
        .outstanding_cnt (outstanding_cnt),
        .err_stray       (err_stray)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        inst_if.req   = 1'b0;
        inst_if.wr    = 1'b0;
        inst_if.size  = 2'd2;
        inst_if.addr  = '0;
        inst_if.wstrb = '0;
        inst_if.wdata = '0;
        data_if.req   = 1'b0;
        data_if.wr    = 1'b0;
        data_if.size  = 2'd2;
        data_if.addr  = '0;
        data_if.wstrb = '0;
        data_if.wdata = '0;
        mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b0;
        mem_if.rdata   = '0;
    endtask

    // Source bookkeeping for the wrap test: 0 = inst, 1 = data.
    bit          exp_q[$];
    bit          exp_head;
    bit          cur_src;
    logic [9:0]  wrap_pat;
    logic [5:0]  starve_pat;
    logic [31:0] val;

    initial begin
        clear_inputs();
        resetn = 1'b0;
        repeat (2) tick();

        // ---------------- reset state ----------------
        check("rst_cnt",      32'(outstanding_cnt), 32'd0);
        check("rst_err",      32'(err_stray),       32'd0);
        check("rst_mem_req",  32'(mem_if.req),      32'd0);
        check("rst_mem_addr", mem_if.addr,          32'd0);
        check("rst_iaok",     32'(inst_if.addr_ok), 32'd0);
        check("rst_ddok",     32'(data_if.data_ok), 32'd0);
        resetn = 1'b1;
        tick();

        // ---------------- single inst read ----------------
        inst_if.req  = 1'b1;
        inst_if.addr = 32'hBFC0_0000;
        settle();
        check("t1_mem_req",   32'(mem_if.req),      32'd1);
        check("t1_mem_addr",  mem_if.addr,          32'hBFC0_0000);
        check("t1_mem_size",  32'(mem_if.size),     32'd2);
        check("t1_mem_wr",    32'(mem_if.wr),       32'd0);
        check("t1_iaok_wait", 32'(inst_if.addr_ok), 32'd0);
        tick();
        check("t1_cnt_wait",  32'(outstanding_cnt), 32'd0);
        mem_if.addr_ok = 1'b1;
        settle();
        check("t1_iaok",      32'(inst_if.addr_ok), 32'd1);
        check("t1_daok",      32'(data_if.addr_ok), 32'd0);
        tick();
        inst_if.req    = 1'b0;
        mem_if.addr_ok = 1'b0;
        settle();
        check("t1_cnt1",      32'(outstanding_cnt), 32'd1);
        check("t1_req_drop",  32'(mem_if.req),      32'd0);
        check("t1_iaok_once", 32'(inst_if.addr_ok), 32'd0);
        tick();
        mem_if.data_ok = 1'b1;
        mem_if.rdata   = 32'h3C01_0000;
        settle();
        check("t1_idok",      32'(inst_if.data_ok), 32'd1);
        check("t1_irdata",    inst_if.rdata,        32'h3C01_0000);
        check("t1_ddok",      32'(data_if.data_ok), 32'd0);
        check("t1_drdata",    data_if.rdata,        32'd0);
        tick();
        mem_if.data_ok = 1'b0;
        settle();
        check("t1_cnt0",      32'(outstanding_cnt), 32'd0);
        check("t1_irdata0",   inst_if.rdata,        32'd0);

        // ---------------- inst + data together ----------------
        inst_if.req   = 1'b1;
        inst_if.addr  = 32'hBFC0_0004;
        data_if.req   = 1'b1;
        data_if.wr    = 1'b1;
        data_if.size  = 2'd2;
        data_if.addr  = 32'h800D_0000;
        data_if.wstrb = 4'hF;
        data_if.wdata = 32'h1234_5678;
        mem_if.addr_ok = 1'b1;
        settle();
        check("t2_mem_wr",    32'(mem_if.wr),       32'd1);
        check("t2_mem_addr",  mem_if.addr,          32'h800D_0000);
        check("t2_mem_wstrb", 32'(mem_if.wstrb),    32'hF);
        check("t2_mem_wdata", mem_if.wdata,         32'h1234_5678);
        check("t2_daok",      32'(data_if.addr_ok), 32'd1);
        check("t2_iaok0",     32'(inst_if.addr_ok), 32'd0);
        tick();
        data_if.req = 1'b0;
        settle();
        check("t2_cnt1",      32'(outstanding_cnt), 32'd1);
        check("t2_iaok",      32'(inst_if.addr_ok), 32'd1);
        check("t2_mem_addr2", mem_if.addr,          32'hBFC0_0004);
        check("t2_mem_wr2",   32'(mem_if.wr),       32'd0);
        check("t2_wstrb2",    32'(mem_if.wstrb),    32'd0);
        check("t2_wdata2",    mem_if.wdata,         32'd0);
        tick();
        inst_if.req    = 1'b0;
        mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b1;
        mem_if.rdata   = 32'hAAAA_0001;
        settle();
        check("t2_cnt2",      32'(outstanding_cnt), 32'd2);
        check("t2_ddok",      32'(data_if.data_ok), 32'd1);
        check("t2_drdata",    data_if.rdata,        32'hAAAA_0001);
        check("t2_idok0",     32'(inst_if.data_ok), 32'd0);
        tick();
        mem_if.rdata = 32'hBBBB_0002;
        settle();
        check("t2_idok",      32'(inst_if.data_ok), 32'd1);
        check("t2_irdata",    inst_if.rdata,        32'hBBBB_0002);
        check("t2_ddok0",     32'(data_if.data_ok), 32'd0);
        tick();
        mem_if.data_ok = 1'b0;
        settle();
        check("t2_cnt0",      32'(outstanding_cnt), 32'd0);

        // ---------------- fill to OUTSTANDING ----------------
        data_if.req    = 1'b1;
        data_if.wr     = 1'b0;
        data_if.wstrb  = 4'h0;
        data_if.addr   = 32'h0000_1000;
        mem_if.addr_ok = 1'b1;
        repeat (4) tick();
        settle();
        check("t3_cnt4",      32'(outstanding_cnt), 32'd4);
        check("t3_full_req",  32'(mem_if.req),      32'd0);
        check("t3_full_daok", 32'(data_if.addr_ok), 32'd0);
        mem_if.data_ok = 1'b1;
        mem_if.rdata   = 32'hD000_0000;
        settle();
        check("t3_pop_ddok",  32'(data_if.data_ok), 32'd1);
        check("t3_pop_req",   32'(mem_if.req),      32'd0);
        tick();
        mem_if.data_ok = 1'b0;
        settle();
        check("t3_cnt3",      32'(outstanding_cnt), 32'd3);
        check("t3_resume",    32'(data_if.addr_ok), 32'd1);
        tick();
        data_if.req    = 1'b0;
        mem_if.addr_ok = 1'b0;
        settle();
        check("t3_cnt4b",     32'(outstanding_cnt), 32'd4);
        for (int i = 0; i < 4; i++) begin
            mem_if.data_ok = 1'b1;
            mem_if.rdata   = 32'hD000_0010 + 32'(i);
            settle();
            check("t3_drain_ddok",  32'(data_if.data_ok), 32'd1);
            check("t3_drain_rdata", data_if.rdata,        32'hD000_0010 + 32'(i));
            tick();
        end
        mem_if.data_ok = 1'b0;
        settle();
        check("t3_cnt0",      32'(outstanding_cnt), 32'd0);

        // ---------------- push+pop at cnt=2 across pointer wrap ----------------
        inst_if.req    = 1'b1;
        inst_if.addr   = 32'hBFC0_0100;
        mem_if.addr_ok = 1'b1;
        tick();
        inst_if.req = 1'b0;
        data_if.req = 1'b1;
        data_if.addr = 32'h0000_2000;
        tick();
        data_if.req = 1'b0;
        exp_q = {1'b0, 1'b1};
        settle();
        check("t4_cnt2",      32'(outstanding_cnt), 32'd2);

        wrap_pat = 10'b0110100111;
        for (int i = 0; i < 10; i++) begin
            cur_src = wrap_pat[i];
            val     = 32'h5000_0000 + 32'(i);
            if (cur_src) begin
                data_if.req  = 1'b1;
                data_if.addr = 32'h0000_3000 + 32'(i * 4);
            end else begin
                inst_if.req  = 1'b1;
                inst_if.addr = 32'hBFC0_0200 + 32'(i * 4);
            end
            mem_if.addr_ok = 1'b1;
            mem_if.data_ok = 1'b1;
            mem_if.rdata   = val;
            exp_head = exp_q.pop_front();
            exp_q.push_back(cur_src);
            settle();
            check("t4_ddok",  32'(data_if.data_ok), 32'(exp_head));
            check("t4_idok",  32'(inst_if.data_ok), 32'(!exp_head));
            check("t4_drd",   data_if.rdata,        exp_head ? val : 32'd0);
            check("t4_ird",   inst_if.rdata,        exp_head ? 32'd0 : val);
            check("t4_aok",   32'(cur_src ? data_if.addr_ok : inst_if.addr_ok), 32'd1);
            tick();
            inst_if.req = 1'b0;
            data_if.req = 1'b0;
            check("t4_cnt_hold", 32'(outstanding_cnt), 32'd2);
        end
        mem_if.addr_ok = 1'b0;
        for (int i = 0; i < 2; i++) begin
            val = 32'h6000_0000 + 32'(i);
            mem_if.data_ok = 1'b1;
            mem_if.rdata   = val;
            exp_head = exp_q.pop_front();
            settle();
            check("t4_drain_ddok", 32'(data_if.data_ok), 32'(exp_head));
            check("t4_drain_idok", 32'(inst_if.data_ok), 32'(!exp_head));
            tick();
        end
        mem_if.data_ok = 1'b0;
        settle();
        check("t4_cnt0",      32'(outstanding_cnt), 32'd0);

        // ---------------- starvation guard ----------------
        // Expected grant per cycle, 1 = data: d d d d i d
        starve_pat = 6'b101111;
        inst_if.req    = 1'b1;
        inst_if.addr   = 32'hBFC0_0300;
        data_if.req    = 1'b1;
        data_if.wr     = 1'b0;
        data_if.addr   = 32'h0000_4000;
        mem_if.addr_ok = 1'b1;
        for (int i = 0; i < 6; i++) begin
            mem_if.data_ok = (i > 0);
            mem_if.rdata   = 32'hC000_0000 + 32'(i);
            settle();
            check("t5_daok", 32'(data_if.addr_ok), 32'(starve_pat[i]));
            check("t5_iaok", 32'(inst_if.addr_ok), 32'(!starve_pat[i]));
            if (i > 0) begin
                check("t5_ddok", 32'(data_if.data_ok), 32'(starve_pat[i-1]));
                check("t5_idok", 32'(inst_if.data_ok), 32'(!starve_pat[i-1]));
            end
            tick();
        end
        inst_if.req    = 1'b0;
        data_if.req    = 1'b0;
        mem_if.addr_ok = 1'b0;
        mem_if.data_ok = 1'b1;
        settle();
        check("t5_last_ddok", 32'(data_if.data_ok), 32'd1);
        tick();
        mem_if.data_ok = 1'b0;
        settle();
        check("t5_cnt0",      32'(outstanding_cnt), 32'd0);

        // ---------------- stray response ----------------
        check("t6_err_pre",   32'(err_stray),       32'd0);
        mem_if.data_ok = 1'b1;
        mem_if.rdata   = 32'hDEAD_BEEF;
        settle();
        check("t6_idok",      32'(inst_if.data_ok), 32'd0);
        check("t6_ddok",      32'(data_if.data_ok), 32'd0);
        check("t6_irdata",    inst_if.rdata,        32'd0);
        tick();
        mem_if.data_ok = 1'b0;
        settle();
        check("t6_err",       32'(err_stray),       32'd1);
        check("t6_cnt0",      32'(outstanding_cnt), 32'd0);
        repeat (3) tick();
        check("t6_err_sticky", 32'(err_stray),      32'd1);

        // ---------------- reset mid-transaction ----------------
        inst_if.req    = 1'b1;
        inst_if.addr   = 32'hBFC0_0400;
        mem_if.addr_ok = 1'b1;
        tick();
        inst_if.req    = 1'b0;
        mem_if.addr_ok = 1'b0;
        check("t7_cnt1",      32'(outstanding_cnt), 32'd1);
        #2;
        resetn = 1'b0;
        settle();
        check("t7_rst_cnt",   32'(outstanding_cnt), 32'd0);
        check("t7_rst_err",   32'(err_stray),       32'd0);
        tick();
        resetn = 1'b1;
        tick();
        mem_if.data_ok = 1'b1;
        mem_if.rdata   = 32'h1111_2222;
        settle();
        check("t7_late_idok", 32'(inst_if.data_ok), 32'd0);
        tick();
        mem_if.data_ok = 1'b0;
        settle();
        check("t7_late_err",  32'(err_stray),       32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
